// File: rtl/nios2os_nios2_oci_dct_packer.sv
// -----------------------------------------------------------------------------
// nios2os_nios2_oci_dct_packer
//
// Direct-compressed-trace packer for the Nios II OCI instruction-trace path.
// Each retired direct branch contributes a 2-bit outcome code:
//   taken = 2'b10, not-taken = 2'b01, 2'b00 = empty slot.
// Codes shift into a 30-bit buffer, with the newest code in bits [1:0].
// A frame closes when any of these holds:
//   - the buffer reaches MAX_ENTRIES entries;
//   - a flush arrives;
//   - tracing is switched off while entries are pending.
// Closed frames go to the trace FIFO over a valid/ready handshake.
// If the frame register is still occupied when a frame must close, the packer
// parks the closed frame in the live buffer (HOLD). Branches retired during
// HOLD are dropped and flagged by the sticky overflow bit.
//
// Optional build macro: DCT_LOSS_CNT_EN
//   Adds loss_cnt[7:0], a saturating count of entries dropped in HOLD.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous reset, active-high
//   trc_on     in   trace enable
//   br_valid   in   one direct branch retired this cycle
//   br_taken   in   outcome of that branch
//   flush_req  in   indirect branch / exception: close the current frame
//   frm_ready  in   downstream accepts frame
//   frm_valid  out  frame register holds a frame
//   frm_data   out  frame {count[3:0], buffer[29:0]}
//   dct_buffer out  live packing buffer
//   dct_count  out  live entry count
//   overflow   out  sticky: at least one entry was dropped
//   loss_cnt   out  (DCT_LOSS_CNT_EN only) dropped-entry count, saturating
// -----------------------------------------------------------------------------
module nios2os_nios2_oci_dct_packer #(
    parameter int MAX_ENTRIES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trc_on,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic        flush_req,
    input  logic        frm_ready,
    output logic        frm_valid,
    output logic [33:0] frm_data,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        overflow
`ifdef DCT_LOSS_CNT_EN
    ,
    output logic [7:0]  loss_cnt
`endif
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_ENTRIES);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_COLLECT,
        ST_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] buffer_d;
    logic [3:0]  count_d;
    logic        frm_valid_d;
    logic [33:0] frm_data_d;
    logic        overflow_d;

    // Buffer and count as they stand after this cycle's branch, if any.
    // A same-cycle branch is always part of the frame that closes with it.
    logic [1:0]  code;
    logic [29:0] app_buffer;
    logic [3:0]  app_count;
    logic        slot_free;
    logic        close;

    assign code       = br_taken ? 2'b10 : 2'b01;
    assign app_buffer = br_valid ? {dct_buffer[27:0], code} : dct_buffer;
    assign app_count  = dct_count + 4'(br_valid);
    // The frame register can take a new frame when it is empty, or when the
    // frame it holds transfers this cycle.
    assign slot_free  = !frm_valid || frm_ready;
    assign close      = (br_valid && (app_count == MAX_CNT)) ||
                        ((flush_req || !trc_on) && (app_count != 4'd0));

`ifdef DCT_LOSS_CNT_EN
    logic [7:0] loss_d;
`endif

    always_comb begin
        // NOTE: every signal gets a default before the case statement.
        // A branch that leaves one unassigned would otherwise infer a latch.
        state_d     = state_q;
        buffer_d    = dct_buffer;
        count_d     = dct_count;
        frm_valid_d = frm_valid && !frm_ready;
        frm_data_d  = frm_data;
        overflow_d  = overflow;
`ifdef DCT_LOSS_CNT_EN
        loss_d      = loss_cnt;
`endif

        unique case (state_q)
            ST_OFF: begin
                if (trc_on) state_d = ST_COLLECT;
            end

            ST_COLLECT: begin
                buffer_d = app_buffer;
                count_d  = app_count;
                if (close) begin
                    if (slot_free) begin
                        frm_data_d  = {app_count, app_buffer};
                        frm_valid_d = 1'b1;
                        buffer_d    = '0;
                        count_d     = '0;
                        state_d     = trc_on ? ST_COLLECT : ST_OFF;
                    end else begin
                        // Frame register is busy: the closed frame waits in
                        // the live buffer.
                        state_d = ST_HOLD;
                    end
                end else if (!trc_on) begin
                    state_d = ST_OFF;
                end
            end

            ST_HOLD: begin
                // The live buffer is a closed frame. New branches cannot be
                // appended, and a flush has nothing left to close.
                if (br_valid) begin
                    overflow_d = 1'b1;
`ifdef DCT_LOSS_CNT_EN
                    if (loss_cnt != 8'hFF) loss_d = loss_cnt + 8'd1;
`endif
                end
                // frm_valid is always 1 here, so a ready frees the slot.
                if (frm_ready) begin
                    frm_data_d  = {dct_count, dct_buffer};
                    frm_valid_d = 1'b1;
                    buffer_d    = '0;
                    count_d     = '0;
                    state_d     = trc_on ? ST_COLLECT : ST_OFF;
                end
            end

            default: state_d = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_OFF;
            dct_buffer <= '0;
            dct_count  <= '0;
            frm_valid  <= 1'b0;
            frm_data   <= '0;
            overflow   <= 1'b0;
`ifdef DCT_LOSS_CNT_EN
            loss_cnt   <= '0;
`endif
        end else begin
            // NOTE: use non-blocking assignments for state. Every register
            // then samples the values from before this edge.
            state_q    <= state_d;
            dct_buffer <= buffer_d;
            dct_count  <= count_d;
            frm_valid  <= frm_valid_d;
            frm_data   <= frm_data_d;
            overflow   <= overflow_d;
`ifdef DCT_LOSS_CNT_EN
            loss_cnt   <= loss_d;
`endif
        end
    end

endmodule

// File: doc/nios2os_nios2_oci_dct_packer.md
Name: nios2os_nios2_oci_dct_packer

Overview:
- Direct-compressed-trace (DCT) packer for the Nios II OCI instruction-trace path.
- Packs per-branch 2-bit outcome codes from retired direct branches into a 30-bit shift buffer with a 4-bit entry count.
- Exposes the live dct_buffer/dct_count pair to the OCI test bench and downstream trace logic.
- Hands completed frames to the trace FIFO over a valid/ready interface.

Parameters:
- MAX_ENTRIES, 15: entries per frame before an automatic emit; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-high
- trc_on  input  1  trace enable
- br_valid  input  1  one direct branch retired this cycle
- br_taken  input  1  outcome of that branch
- flush_req  input  1  indirect branch or exception; close the current frame
- frm_ready  input  1  downstream accepts frame
- frm_valid  output  1  frame register holds a frame
- frm_data  output  34  frame: {count[3:0], buffer[29:0]}
- dct_buffer  output  30  live packing buffer
- dct_count  output  4  live entry count
- overflow  output  1  sticky; at least one entry was dropped

Behaviour:
- Reset (asynchronous, active-high) clears all outputs: dct_buffer=0, dct_count=0, frm_valid=0, frm_data=0, overflow=0. State goes to OFF.
- Codes: taken=2'b10, not-taken=2'b01, 2'b00=empty slot.
- Append: dct_buffer <= {dct_buffer[27:0], code}; dct_count <= dct_count+1. Newest entry is always in bits [1:0].
- The live registers update one cycle after br_valid.
- States:
  - OFF: trc_on=0; inputs ignored; live registers stay 0. trc_on=1 -> COLLECT.
  - COLLECT: appends branches. The frame closes when any of these holds:
    - the append makes count==MAX_ENTRIES;
    - flush_req=1 and post-append count>0;
    - trc_on falls and count>0.
  - HOLD: a frame must close but the frame register is occupied and frm_ready=0.
- Frame close:
  - If frm_valid=0 or frm_ready=1 this cycle, the closing {count, buffer} (including any same-cycle append) loads into frm_data next cycle and frm_valid=1.
  - Live buffer and count clear to 0 in that same cycle.
  - Next state is COLLECT if trc_on=1, else OFF.
  - Otherwise go to HOLD; the live buffer keeps its contents.
- In HOLD:
  - br_valid entries are dropped and overflow is set.
  - flush_req is absorbed; the pending frame is already closed.
  - When frm_ready=1, the held frame loads and the live registers clear. Next state is COLLECT or OFF per trc_on.
- Handshake:
  - The frame transfers on frm_valid && frm_ready.
  - frm_data is stable while frm_valid=1 and frm_ready=0.
  - frm_valid drops the cycle after a transfer unless a new frame loads in the same cycle.
- Simultaneous br_valid and flush_req: the branch is appended first, then the frame closes containing it.
- Simultaneous br_valid and trc_on falling: the branch is appended, then the frame closes.
- flush_req with count==0 and no branch: no frame is produced.
- dct_count never exceeds MAX_ENTRIES; there is no wrap-around.
- overflow clears only on reset.
- Reset mid-frame or mid-HOLD: all state and the pending frame are discarded immediately.

Optional Feature:
- Macro: DCT_LOSS_CNT_EN.
- When defined:
  - Adds output loss_cnt [7:0].
  - Counts entries dropped in HOLD; saturates at 255.
  - Clears on reset; reset value 0.
- When undefined:
  - Port absent; only the sticky overflow bit reports loss.

Test Plan:
- Reset, trc_on=1, 3 branches taken/not/taken, then flush_req -> dct_buffer=30'h26 before the flush. Frame {4'd3, 30'h26} with frm_valid=1 one cycle after flush_req. Live registers cleared.
- 15 consecutive taken branches, frm_ready=1 -> frame {4'd15, 30'h2AAAAAAA} one cycle after the 15th branch. dct_count returns to 0.
- Frame pending with frm_ready=0, then 15 more branches plus 2 extra -> HOLD entered, overflow=1, loss_cnt=2 (macro on). Raising frm_ready transfers the first frame, then the held frame.
- br_valid(not-taken) and flush_req in the same cycle at count=0 -> frame {4'd1, 30'h1}.
- flush_req at count=0 with no branch -> no frm_valid. trc_on falling at count=2 -> frame with count=2, state OFF.
- Assert reset with count=7 and frm_valid=1 -> all outputs 0 immediately (asynchronous), with no clock edge required.
